// File: rtl/colour_palette_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | colour_pkg: shared types, defaults and default-palette generator           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package colour_pkg;

  localparam int DEF_CH_W = 8;
  localparam int MAX_CH_W = 16;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Channel k of the {R,G,B} word takes its level from idx[k] (B=0, G=1, R=2).
  function automatic logic [3*MAX_CH_W-1:0] default_colour(input logic [2:0]   idx,
                                                           input int unsigned ch_w);
    logic [3*MAX_CH_W-1:0] res;
    res = '0;
    for (int unsigned b = 0; b < 3*MAX_CH_W; b++) begin
      if (b < 3*ch_w) res[b] = idx[2'(b / ch_w)];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/colour_palette_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | colour_palette_if: lookup, palette-write and result signals                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface colour_palette_if
  import colour_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int CH_W  = DEF_CH_W
) ();

  logic                enable;
  logic [IDX_W-1:0]    colour;
  logic [CH_W-1:0]     bright;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [3*CH_W-1:0]   wr_data;
  logic [3*CH_W-1:0]   rgb;
  logic                valid;
  logic                busy;

  modport master (
    output enable, colour, bright, wr_en, wr_addr, wr_data,
    input  rgb, valid, busy
  );

  modport slave (
    input  enable, colour, bright, wr_en, wr_addr, wr_data,
    output rgb, valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/colour_palette_scale.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | colour_scale: one channel of the stage-2 brightness multiply and register  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module colour_scale #(
  parameter int CH_W = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_en,
  input  wire logic [CH_W-1:0] i_ch,
  input  wire logic [CH_W-1:0] i_bright,
  output logic      [CH_W-1:0] o_ch
);

  localparam int PROD_W = 2*CH_W + 1;

  logic [CH_W:0]     w_bp1;
  logic [PROD_W-1:0] w_prod;
  logic [CH_W-1:0]   r_ch;
  logic              w_unused;

  // bright+1 makes all-ones an exact unity gain after the >>CH_W.
  assign w_bp1    = {1'b0, i_bright} + (CH_W+1)'(1);
  assign w_prod   = PROD_W'(i_ch) * PROD_W'(w_bp1);
  assign w_unused = ^{w_prod[PROD_W-1], w_prod[CH_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch <= '0;
    end else if (i_en) begin
      r_ch <= w_prod[2*CH_W-1:CH_W];
    end
  end

  assign o_ch = r_ch;

endmodule
`default_nettype wire

// File: rtl/colour_palette.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | colour_palette: writable palette lookup with brightness scaling            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module colour_palette
  import colour_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int CH_W  = DEF_CH_W
) (
  input  wire logic        clk,
  input  wire logic        rst,
  colour_palette_if.slave  bus
);

  localparam int DEPTH = 2**IDX_W;
  localparam int RGB_W = 3*CH_W;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic               w_init_we;
  logic               w_last;

  logic [RGB_W-1:0]   r_pal [DEPTH];
  logic [3*MAX_CH_W-1:0] w_def_full;
  logic [RGB_W-1:0]   w_def;
  logic               w_unused;

  logic               w_run;
  logic               w_user_we;
  logic               w_accept;
  logic [RGB_W-1:0]   w_rd;

  logic               r_s1_vld;
  logic [RGB_W-1:0]   r_s1_rgb;
  logic [CH_W-1:0]    r_s1_bright;
  logic               r_s2_vld;
  logic [RGB_W-1:0]   w_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init_we) r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_we   = 1'b0;
    w_last      = (r_idx == IDX_W'(DEPTH-1));
    case (r_state)
      INIT: begin
        w_init_we = 1'b1;
        if (w_last) w_state_nxt = RUN;
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // Indices wider than 3 bits alias onto the 8 legacy colours.
  assign w_def_full = default_colour(3'(r_idx), CH_W);
  assign w_def      = w_def_full[RGB_W-1:0];
  assign w_unused   = ^w_def_full;

  assign w_run     = (r_state == RUN) && !rst;
  assign w_user_we = w_run && bus.wr_en;
  assign w_accept  = w_run && bus.enable;

  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_pal[r_idx] <= w_def;
    end else if (w_user_we) begin
      r_pal[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Write-first: a same-cycle write to the looked-up entry wins over the array.
  assign w_rd = (w_user_we && (bus.wr_addr == bus.colour)) ? bus.wr_data
                                                           : r_pal[bus.colour];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_rgb    <= '0;
      r_s1_bright <= '0;
      r_s2_vld    <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      r_s2_vld <= r_s1_vld;
      if (w_accept) begin
        r_s1_rgb    <= w_rd;
        r_s1_bright <= bus.bright;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    colour_scale #(.CH_W(CH_W)) u_scale (
      .clk      (clk),
      .rst      (rst),
      .i_en     (r_s1_vld),
      .i_ch     (r_s1_rgb[g*CH_W +: CH_W]),
      .i_bright (r_s1_bright),
      .o_ch     (w_rgb[g*CH_W +: CH_W])
    );
  end

  assign bus.rgb   = w_rgb;
  assign bus.valid = r_s2_vld;
  assign bus.busy  = (r_state == INIT) || rst;

endmodule
`default_nettype wire
